// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO push port between NREQ write-side
// requesters. A grant lasts up to BURST accepted words. One IDLE cycle always
// separates two grants. Also keeps push and stall statistics for debug.
//
// Handshake: a requester raises req[i] and holds req[i] and its req_data
// slice stable until it sees ack[i]. ack[i] is high in exactly the cycle its
// word is pushed, which is when it owns the port, req[i] is high and full is
// low. Dropping req[i] without an ack is legal and ends the grant. push never
// rises while full is high, so full acts as the FIFO's ready, used
// combinationally.
module fifo_wr_arbiter #(
    parameter int NREQ   = 4,
    parameter int DWIDTH = 8,
    parameter int BURST  = 4,
    parameter int IDW    = 2
) (
    input  logic                   wclk,
    input  logic                   reset_L,
    input  logic [NREQ-1:0]        req,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    output logic [NREQ-1:0]        ack,
    output logic [NREQ-1:0]        grant,
    output logic [IDW-1:0]         grant_id,
    input  logic                   full,
    output logic                   push,
    output logic [DWIDTH-1:0]      wdata,
    output logic [15:0]            push_cnt,
    output logic [15:0]            stall_cnt,
    output logic                   state_dbg,
    output logic [3:0]             beat_dbg
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    state_t          state, state_nxt;
    logic [NREQ-1:0] grant_nxt;
    logic [IDW-1:0]  grant_id_nxt;
    logic [IDW-1:0]  last, last_nxt;
    logic [3:0]      beat, beat_nxt;
    logic [15:0]     push_cnt_nxt, stall_cnt_nxt;

    logic            pick_found;
    logic [IDW-1:0]  pick_idx;
    logic            req_g;
    logic            done;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        int cand;
        logic [IDW-1:0] cand_idx;
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        cand_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand     = (int'(last) + k) % NREQ;
            cand_idx = IDW'(cand);
            if (!pick_found && req[cand_idx]) begin
                pick_found = 1'b1;
                pick_idx   = cand_idx;
            end
        end
    end

    // Data path: forward the granted requester's word and decode push/ack
    always_comb begin
        req_g = req[grant_id];
        push  = (state == OWN) && req_g && !full;
        ack   = '0;
        ack[grant_id] = push;
        wdata = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id == IDW'(i)) begin
                wdata = req_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    // Next-state logic: grant selection, burst accounting, statistics
    always_comb begin
        state_nxt     = state;
        grant_nxt     = grant;
        grant_id_nxt  = grant_id;
        last_nxt      = last;
        beat_nxt      = beat;
        push_cnt_nxt  = push_cnt;
        stall_cnt_nxt = stall_cnt;
        done          = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt    = OWN;
                    grant_nxt    = '0;
                    grant_nxt[pick_idx] = 1'b1;
                    grant_id_nxt = pick_idx;
                    last_nxt     = pick_idx;
                    beat_nxt     = '0;
                end
            end
            OWN: begin
                if (push) begin
                    beat_nxt     = beat + 4'd1;
                    push_cnt_nxt = push_cnt + 16'd1;
                end
                if (req_g && full && (stall_cnt != 16'hFFFF)) begin
                    stall_cnt_nxt = stall_cnt + 16'd1;
                end
                done = !req_g || (push && (beat == 4'(BURST - 1)));
                if (done) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

    // State register; reset leaves last at NREQ-1 so requester 0 wins first
    always_ff @(posedge wclk or negedge reset_L) begin
        if (!reset_L) begin
            state     <= IDLE;
            grant     <= '0;
            grant_id  <= '0;
            last      <= IDW'(NREQ - 1);
            beat      <= '0;
            push_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            grant     <= grant_nxt;
            grant_id  <= grant_id_nxt;
            last      <= last_nxt;
            beat      <= beat_nxt;
            push_cnt  <= push_cnt_nxt;
            stall_cnt <= stall_cnt_nxt;
        end
    end

    // Debug view of the FSM
    always_comb begin
        state_dbg = (state == OWN);
        beat_dbg  = beat;
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: a table of per-cycle vectors plus hand-written
// sequences, with a scoreboard of {grant_id, wdata} words checked on each push.
module tb_fifo_wr_arbiter;

    localparam int W = 10;  // {id[1:0], data[7:0]}

    // clock / reset
    logic wclk = 1'b0;
    always #5 wclk = ~wclk;

    // main DUT signals
    logic        reset_L;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        full;
    logic        push;
    logic [7:0]  wdata;
    logic [15:0] push_cnt;
    logic [15:0] stall_cnt;
    logic        state_dbg;
    logic [3:0]  beat_dbg;

    fifo_wr_arbiter #(.NREQ(4), .DWIDTH(8), .BURST(4), .IDW(2)) dut (
        .wclk(wclk), .reset_L(reset_L), .req(req), .req_data(req_data),
        .ack(ack), .grant(grant), .grant_id(grant_id), .full(full),
        .push(push), .wdata(wdata), .push_cnt(push_cnt), .stall_cnt(stall_cnt),
        .state_dbg(state_dbg), .beat_dbg(beat_dbg)
    );

    // counter-wrap instances
    logic        w_rst;
    logic [1:0]  w_req, w_ack, w_grant;
    logic [15:0] w_data;
    logic [0:0]  w_gid;
    logic        w_full, w_push, w_state;
    logic [7:0]  w_wdata;
    logic [15:0] w_push_cnt, w_stall_cnt;
    logic [3:0]  w_beat;

    fifo_wr_arbiter #(.NREQ(2), .DWIDTH(8), .BURST(16), .IDW(1)) u_wrap (
        .wclk(wclk), .reset_L(w_rst), .req(w_req), .req_data(w_data),
        .ack(w_ack), .grant(w_grant), .grant_id(w_gid), .full(w_full),
        .push(w_push), .wdata(w_wdata), .push_cnt(w_push_cnt), .stall_cnt(w_stall_cnt),
        .state_dbg(w_state), .beat_dbg(w_beat)
    );

    logic [1:0]  s_req, s_ack, s_grant;
    logic [15:0] s_data;
    logic [0:0]  s_gid;
    logic        s_full, s_push, s_state;
    logic [7:0]  s_wdata;
    logic [15:0] s_push_cnt, s_stall_cnt;
    logic [3:0]  s_beat;

    fifo_wr_arbiter #(.NREQ(2), .DWIDTH(8), .BURST(4), .IDW(1)) u_stall (
        .wclk(wclk), .reset_L(w_rst), .req(s_req), .req_data(s_data),
        .ack(s_ack), .grant(s_grant), .grant_id(s_gid), .full(s_full),
        .push(s_push), .wdata(s_wdata), .push_cnt(s_push_cnt), .stall_cnt(s_stall_cnt),
        .state_dbg(s_state), .beat_dbg(s_beat)
    );

    // bookkeeping
    int n_checks = 0;
    int n_fail   = 0;
    int mon_pushes = 0;
    logic [W-1:0] exp_q[$];
    logic [7:0] d[4];

    typedef struct {
        logic [3:0] req;
        logic       full;
        logic       exp_push;
        logic [3:0] exp_grant;
        logic       exp_own;
    } vec_t;
    vec_t vecs[21];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] oh2idx(input logic [3:0] v);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
        return r;
    endfunction

    task automatic set_data();
        req_data = {d[3], d[2], d[1], d[0]};
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    // scoreboard: every push must match the next expected {id, data}
    always @(negedge wclk) begin
        if (reset_L && push) begin
            logic [W-1:0] e;
            logic [3:0]   oh;
            mon_pushes++;
            if (exp_q.size() == 0) begin
                check("unexpected_push", {grant_id, wdata}, 32'h0);
            end else begin
                e = exp_q.pop_front();
                oh = 4'b0001 << e[9:8];
                check("sb_grant_id", grant_id, e[9:8]);
                check("sb_wdata", wdata, e[7:0]);
                check("sb_ack", ack, oh);
            end
        end
    end

    function automatic vec_t mk(input logic [3:0] r, input logic f, input logic p,
                                input logic [3:0] g, input logic o);
        vec_t v;
        v.req = r; v.full = f; v.exp_push = p; v.exp_grant = g; v.exp_own = o;
        return v;
    endfunction

    initial begin
        int cnt[4];
        int nexp[4];
        int cyc;
        int start;
        int wcount;
        int order[5];

        // single requester then back-pressure on requester 2
        vecs[0] = mk(4'b0001, 0, 0, 4'b0000, 0);
        for (int i = 1; i <= 4; i++) vecs[i] = mk(4'b0001, 0, 1, 4'b0001, 1);
        vecs[5] = mk(4'b0001, 0, 0, 4'b0000, 0);
        for (int i = 6; i <= 9; i++) vecs[i] = mk(4'b0001, 0, 1, 4'b0001, 1);
        vecs[10] = mk(4'b0100, 0, 0, 4'b0000, 0);
        vecs[11] = mk(4'b0100, 0, 1, 4'b0100, 1);
        vecs[12] = mk(4'b0100, 0, 1, 4'b0100, 1);
        for (int i = 13; i <= 17; i++) vecs[i] = mk(4'b0100, 1, 0, 4'b0100, 1);
        vecs[18] = mk(4'b0100, 0, 1, 4'b0100, 1);
        vecs[19] = mk(4'b0100, 0, 1, 4'b0100, 1);
        vecs[20] = mk(4'b0000, 0, 0, 4'b0000, 0);

        reset_L = 1'b0; req = '0; full = 1'b0; req_data = '0;
        w_rst = 1'b0; w_req = '0; w_full = 1'b0; w_data = 16'hA55A;
        s_req = '0; s_full = 1'b1; s_data = 16'h3CC3;
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
        set_data();

        // reset state
        repeat (2) @(posedge wclk);
        @(negedge wclk);
        check("rst_grant", grant, 4'b0000);
        check("rst_grant_id", grant_id, 2'd0);
        check("rst_push", push, 1'b0);
        check("rst_ack", ack, 4'b0000);
        check("rst_state", state_dbg, 1'b0);
        check("rst_push_cnt", push_cnt, 16'd0);
        check("rst_stall_cnt", stall_cnt, 16'd0);
        tick();
        reset_L = 1'b1;

        // table-driven vectors
        for (int i = 0; i < 21; i++) begin
            req = vecs[i].req;
            full = vecs[i].full;
            set_data();
            if (vecs[i].exp_push)
                exp_q.push_back({oh2idx(vecs[i].exp_grant), d[oh2idx(vecs[i].exp_grant)]});
            @(negedge wclk);
            check($sformatf("tbl%0d_push", i), push, vecs[i].exp_push);
            check($sformatf("tbl%0d_grant", i), grant, vecs[i].exp_grant);
            check($sformatf("tbl%0d_state", i), state_dbg, vecs[i].exp_own);
            if (i == 10) check("push_cnt_after_10", push_cnt, 16'd8);
            tick();
        end
        check("tbl_push_cnt", push_cnt, 16'd12);
        check("tbl_stall_cnt", stall_cnt, 16'd5);

        // all four requesting after a fresh reset: order 0,1,2,3,0
        reset_L = 1'b0;
        tick();
        reset_L = 1'b1;
        check("rst2_push_cnt", push_cnt, 16'd0);
        order[0] = 0; order[1] = 1; order[2] = 2; order[3] = 3; order[4] = 0;
        for (int i = 0; i < 4; i++) begin
            cnt[i] = 0;
            nexp[i] = 0;
            d[i] = 8'($urandom_range(0, 255));
        end
        for (int g = 0; g < 5; g++) begin
            for (int k = 0; k < 4; k++) begin
                exp_q.push_back({2'(order[g]), 8'(d[order[g]] + 8'(nexp[order[g]]))});
                nexp[order[g]]++;
            end
        end
        req = 4'hF;
        start = mon_pushes;
        cyc = 0;
        while (cyc < 100 && (mon_pushes - start) < 20) begin
            set_data();
            req_data = {8'(d[3] + 8'(cnt[3])), 8'(d[2] + 8'(cnt[2])),
                        8'(d[1] + 8'(cnt[1])), 8'(d[0] + 8'(cnt[0]))};
            @(negedge wclk);
            for (int i = 0; i < 4; i++) if (ack[i]) cnt[i]++;
            tick();
            cyc++;
        end
        req = '0;
        check("all4_pushes", mon_pushes - start, 20);
        check("all4_cycles", cyc, 25);
        check("all4_acks_req0", cnt[0], 8);
        check("all4_acks_req3", cnt[3], 4);

        // early release: requester 1 drops after 2 acks, requester 3 follows
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
        set_data();
        req = 4'b1010;
        repeat (2) exp_q.push_back({2'd1, d[1]});
        repeat (4) exp_q.push_back({2'd3, d[3]});
        @(negedge wclk);
        check("er_idle0", state_dbg, 1'b0);
        tick();
        @(negedge wclk);
        check("er_grant1", grant, 4'b0010);
        check("er_push1", push, 1'b1);
        tick();
        @(negedge wclk);
        check("er_push2", push, 1'b1);
        tick();
        req = 4'b1000;
        @(negedge wclk);
        check("er_drop_push", push, 1'b0);
        check("er_drop_own", state_dbg, 1'b1);
        tick();
        @(negedge wclk);
        check("er_bubble_state", state_dbg, 1'b0);
        check("er_bubble_grant", grant, 4'b0000);
        tick();
        @(negedge wclk);
        check("er_grant3", grant, 4'b1000);
        check("er_grant_id3", grant_id, 2'd3);
        check("er_beat_restart", beat_dbg, 4'd0);
        check("er_push3", push, 1'b1);
        repeat (4) tick();
        req = '0;
        @(negedge wclk);
        check("er_end_state", state_dbg, 1'b0);
        tick();

        // asynchronous reset in the middle of a burst
        for (int i = 0; i < 4; i++) d[i] = 8'($urandom_range(0, 255));
        set_data();
        req = 4'hF;
        exp_q.push_back({2'd0, d[0]});
        tick();
        tick();
        #2;
        check("ar_before_push", push, 1'b1);
        reset_L = 1'b0;
        #1;
        check("ar_push", push, 1'b0);
        check("ar_ack", ack, 4'b0000);
        check("ar_grant", grant, 4'b0000);
        check("ar_state", state_dbg, 1'b0);
        check("ar_push_cnt", push_cnt, 16'd0);
        check("ar_stall_cnt", stall_cnt, 16'd0);
        tick();
        reset_L = 1'b1;
        tick();
        check("ar_first_grant", grant, 4'b0001);
        check("ar_first_grant_id", grant_id, 2'd0);
        req = '0;
        tick();

        // counter wrap and stall saturation, run in parallel
        w_req = 2'b01;
        w_full = 1'b0;
        s_req = 2'b01;
        s_full = 1'b1;
        w_rst = 1'b1;
        wcount = 0;
        cyc = 0;
        while (cyc < 80000 && wcount < 65536) begin
            @(negedge wclk);
            if (w_push) begin
                wcount++;
                if (wcount == 65536) check("push_cnt_ffff", w_push_cnt, 16'hFFFF);
            end
            cyc++;
        end
        tick();
        w_req = '0;
        check("wrap_count_reached", wcount, 65536);
        check("push_cnt_wrap", w_push_cnt, 16'h0000);
        check("stall_sat", s_stall_cnt, 16'hFFFF);
        check("stall_push_cnt", s_push_cnt, 16'h0000);
        check("stall_grant_held", s_grant, 2'b01);
        tick();
        check("stall_sat_hold", s_stall_cnt, 16'hFFFF);

        check("sb_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares the single push port of `async_fifo_top` between NREQ requesters in the write clock domain. It grants one requester at a time for a bounded burst, forwards that requester's data to `wdata`, and honours `full` back-pressure so the FIFO is never overflowed. It sits between the write-side producers and the FIFO's `push`/`wdata`/`full` pins, and also keeps push and stall statistics for debug.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `DWIDTH`, default 8: data width; matches the FIFO `DWIDTH`.
- `BURST`, default 4: maximum pushes per grant, 1..16.
- `IDW`, default 2: width of `grant_id`; equals ceil(log2(NREQ)).
- `wclk`  in  1  write-domain clock; the only clock.
- `reset_L`  in  1  asynchronous, active-low reset.
- `req`  in  NREQ  per-requester request; held high while data is pending.
- `req_data`  in  NREQ*DWIDTH  packed data; requester i uses bits [i*DWIDTH +: DWIDTH].
- `ack`  out  NREQ  one-hot, combinational; high in the cycle requester i's word is pushed.
- `grant`  out  NREQ  one-hot registered grant; all zero in IDLE.
- `grant_id`  out  IDW  index of the current or last granted requester.
- `full`  in  1  FIFO full flag, synchronous to `wclk`.
- `push`  out  1  FIFO push, combinational.
- `wdata`  out  DWIDTH  FIFO write data, combinational mux of the granted `req_data`.
- `push_cnt`  out  16  total accepted pushes; wraps modulo 2^16.
- `stall_cnt`  out  16  cycles spent in OWN with `req[g]` high and `full` high; saturates at 0xFFFF.

## Operation
- States: IDLE and OWN. The registers are `state`, `grant`, `grant_id`, the `last` pointer, `beat` (a 4-bit burst counter) and the two counters.
- IDLE:
  - If `req` is all zero, stay in IDLE.
  - Otherwise select the first i with `req[i]`=1, searching in the order last+1, last+2, … modulo NREQ.
  - At the edge, set `grant` to one-hot i, `grant_id`=i, `last`=i, `beat`=0, and move to OWN.
- OWN, with g = `grant_id`:
  - `push` = `req[g]` & ~`full`.
  - `wdata` = `req_data[g]`.
  - `ack[g]` = `push`; all other `ack` bits are 0.
- On each `push`, `beat` increments and `push_cnt` increments.
- OWN to IDLE at the edge when either:
  - `req[g]`=0, or
  - `push`=1 and `beat`=BURST-1.
- There is always exactly one IDLE bubble cycle between grants. Because of this, a requester that is still requesting re-competes fairly and is served after the other pending requesters.
- While `full`=1 in OWN:
  - No push is issued and the grant is held.
  - `beat` is unchanged.
  - `stall_cnt` increments if `req[g]`=1.
- Requester rules:
  - A requester must hold `req` and `req_data` stable until it sees `ack`.
  - Deasserting `req` without an ack is legal and ends the grant.
- In IDLE, `push`, `ack` and `grant` are all 0, and `wdata` = `req_data[grant_id]`. This value is don't-care for the FIFO.
- Width and arithmetic rules:
  - `beat` compares against BURST-1. When BURST=1, every push ends the grant.
  - `push_cnt` wraps from 0xFFFF to 0x0000.
  - `stall_cnt` holds at 0xFFFF.

## Timing
- Reset (asynchronous, `reset_L`=0):
  - `state`=IDLE, `grant`=0, `grant_id`=0, `last`=NREQ-1 (so requester 0 wins first), `beat`=0, both counters 0.
  - `push` and `ack` go low immediately, because they decode from `state`.
- Reset mid-burst drops the grant within the same delta. No push occurs while `reset_L`=0.
- Request-to-push latency: `req` rising in IDLE is sampled at edge k, `grant` is valid after edge k, and the first push is sampled by the FIFO at edge k+1.
- Sustained throughput: BURST words per BURST+1 cycles when `full`=0.
- `full` is used combinationally in the same cycle. `push` never asserts in a cycle where `full`=1, so a FIFO with one free slot accepts exactly one word.
- If `req` changes simultaneously with a grant edge, the IDLE decision uses the value sampled at that edge.

## Test plan
- Reset then single requester: `req`=0001 held, `full`=0, BURST=4.
  - Expect 4 pushes on cycles 1–4, then 1 idle cycle, then 4 more.
  - After 10 cycles, `push_cnt`=8.
- All four requesting, `full`=0, BURST=4.
  - Grant order 0,1,2,3,0; each grant carries exactly 4 acks.
  - `wdata` equals the corresponding `req_data` slice on each ack.
- Back-pressure: requester 2 granted, `full` forced high for 5 cycles mid-burst.
  - `push`=0 for those 5 cycles, `grant` is held, `stall_cnt`=5.
  - The burst completes with 4 total pushes after `full` falls.
- Early release: requester 1 drops `req` after 2 acks while requester 3 is requesting.
  - OWN goes to IDLE in the next cycle, then requester 3 is granted.
  - `beat` restarts at 0.
- Asynchronous reset asserted mid-burst, between clock edges.
  - `push`, `ack` and `grant` go 0 immediately and the counters clear.
  - After release with `req`=1111, requester 0 is granted first.
- Counter wrap: preload or run 65536 pushes.
  - `push_cnt` reads 0x0000.
  - `stall_cnt` driven past 65535 stall cycles stays at 0xFFFF.
